l2_count_ctrl: RTL and testbench
================================

# l2_count_ctrl

Sequencing controller for the lab's Part 3 counter display. It conditions the raw DE1 pushbuttons and runs a 4-bit counter in manual-step or timed auto-step mode, selected by the switches. It also drives one 7-segment digit and status LEDs. It sits between the board I/O and the top-level display mux, which enables it when the Part 3 switch code is selected.

## Interface
- TICK_DIV, 24000000: auto-step period in clock cycles (1 s at 24 MHz).
- DB_CYCLES, 240000: debounce stability window in cycles (10 ms).
- clock, in, 1: 24 MHz board clock; all logic on the rising edge.
- reset, in, 1: synchronous, active-high.
- enable, in, 1: high while the top level selects Part 3.
- key_n, in, 2: raw pushbuttons, active-low. Bit 0 = STEP (KEY0), bit 1 = CTRL (KEY1).
- mode, in, 2: mode[1] 0 = manual, 1 = auto; mode[0] 0 = up, 1 = down.
- count, out, 4: current counter value.
- seg, out, 7: active-low gfedcba code for count.
- wrap, out, 1: one-cycle pulse when the counter wraps.
- running, out, 1: high in RUN_AUTO.

## Operation
- **Input path.** Each key_n bit passes through a 2-FF synchronizer, then a debouncer, then a falling-edge detector. The detector produces a one-cycle press pulse: press0 for STEP, press1 for CTRL.
- **Debouncer.**
  - Each key has a counter that clears whenever the synced sample equals the stable level.
  - The counter increments while the sample differs from the stable level.
  - The stable level takes the sample when the counter is at DB_CYCLES-1 and the sample still differs.
  - Reset: stable = 1, counter = 0.
- **States.** IDLE, RUN_MAN, RUN_AUTO, PAUSE.
- **Transitions.**
  - enable = 0 in any state → IDLE, and count clears to 0.
  - IDLE with enable = 1 → RUN_MAN if mode[1] = 0, else RUN_AUTO.
  - RUN_MAN → RUN_AUTO when mode[1] = 1.
  - RUN_AUTO or PAUSE → RUN_MAN when mode[1] = 0.
  - Every mode change preserves count.
  - RUN_AUTO with press1 → PAUSE.
  - PAUSE with press1 → RUN_AUTO.
- **Actions.**
  - RUN_MAN: press0 steps count by ±1 (direction from mode[0]); press1 clears count to 0.
  - RUN_AUTO: press0 is ignored; a prescaler tick steps count.
  - PAUSE: press0 single-steps count; no auto steps occur.
- **Simultaneous events.**
  - RUN_MAN with press0 and press1 in the same cycle: clear wins and no step occurs.
  - PAUSE with press0 and press1 in the same cycle: resume wins and the step is dropped.
  - A mode change and a press in the same cycle: the state changes and the press is dropped.
- **Arithmetic.** Modulo 16.
  - Up from 15 → 0 asserts wrap.
  - Down from 0 → 15 asserts wrap.
  - wrap is registered with the same edge that updates count.
  - Clear never asserts wrap.
- **Prescaler.**
  - Counts 0..TICK_DIV-1 only in RUN_AUTO.
  - Tick = prescaler at TICK_DIV-1; the prescaler then returns to 0.
  - The prescaler clears on every entry to RUN_AUTO and holds at 0 in all other states.
- **seg encoding.** Registered from count, in gfedcba order:
  - 0 1000000, 1 1111001, 2 0100100, 3 0110000
  - 4 0011001, 5 0010010, 6 0000010, 7 1111000
  - 8 0000000, 9 0010000, A 0001000, b 0000011
  - C 1000110, d 0100001, E 0000110, F 0001110

## Timing
- Reset values: state IDLE, count 0, seg 1000000, wrap 0, running 0, prescaler 0. Synchronizer and stable levels reset to 1.
- A reset asserted mid-operation, including mid-debounce or mid-prescale, overrides every other input on that edge.
- Press latency: count changes on the (DB_CYCLES+3)th rising edge after key_n is first sampled low, provided the key is held low throughout.
- A bounce shorter than DB_CYCLES cycles produces no press.
- Release generates no event.
- seg lags count by exactly one cycle.
- running is registered and reflects the state in the same cycle.
- Auto step: the first step occurs TICK_DIV edges after entry to RUN_AUTO, then every TICK_DIV edges.

## Configuration
- DEBOUNCE_EN defined: the debouncer is present as specified above.
- DEBOUNCE_EN undefined: the debouncer is omitted and the stable level equals the synchronizer output. Press latency becomes 3 edges, and DB_CYCLES is unused.

## Test plan
All scenarios use TICK_DIV = 8 and DB_CYCLES = 4.
- **Reset.** Hold reset for 2 cycles with enable = 1 → count 0, seg 1000000, wrap 0, running 0. Releasing reset in mode 00 → RUN_MAN.
- **Manual up with wrap.** Mode 00, 16 clean STEP presses → count runs 1..15 then 0. wrap pulses exactly once, on the 16th press. Each update lands 7 edges after the press.
- **Bounce reject.** STEP low for 3 cycles, then high, repeated 5 times → count unchanged. A 20-cycle hold → count +1.
- **Auto down with pause.** Mode 11 from count 2 → count 1, 0, 15 at edges 8, 16, 24 after entry, with wrap on the 15. CTRL press → count frozen, running 0. STEP press in PAUSE → 14.
- **Simultaneous presses.** RUN_MAN at count 9, STEP and CTRL pressed in the same cycle → count 0, wrap 0.
- **Mode and enable changes.** Mode switched 00 → 10 at count 5 → the next auto step after exactly 8 edges gives 6. Dropping enable → count 0, state IDLE, running 0.

Source files
------------

// File: rtl/l2_count_ctrl.sv
// l2_count_ctrl: STEP/CTRL pushbuttons drive a mod-16 counter in manual, timed-auto or paused mode, with 7-seg and status outputs; DEBOUNCE_EN adds the key debouncer.
// Latency: a held key moves count DB_CYCLES+3 edges after it is first sampled low (3 edges without DEBOUNCE_EN); seg follows count by one cycle.
// Backpressure: none; presses landing in IDLE, with enable low or on a mode-change edge are dropped, never queued.
module l2_count_ctrl #(
    parameter int TICK_DIV  = 24000000,
    parameter int DB_CYCLES = 240000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [1:0] key_n,
    input  logic [1:0] mode,
    output logic [3:0] count,
    output logic [6:0] seg,
    output logic       wrap,
    output logic       running
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN_MAN,
        RUN_AUTO,
        PAUSE
    } state_t;

    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    stable;
    logic [1:0]    stable_d;
    logic [1:0]    press;
    state_t        state;
    logic [PW-1:0] presc;
    logic          tick;
    logic [4:0]    stepped;

    // Keys idle high, so every stage of the input path resets to 1.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1    <= 2'b11;
            sync2    <= 2'b11;
            stable_d <= 2'b11;
        end else begin
            sync1    <= key_n;
            sync2    <= sync1;
            stable_d <= stable;
        end
    end

`ifdef DEBOUNCE_EN
    localparam int DW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DW-1:0] DB_LAST = DW'(DB_CYCLES - 1);

    logic [DW-1:0] db_cnt [2];

    // The stable level only moves after DB_CYCLES consecutive differing samples.
    always_ff @(posedge clock) begin
        if (reset) begin
            stable    <= 2'b11;
            db_cnt[0] <= '0;
            db_cnt[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    stable[i] <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end
`else
    // Synchronized level is used directly; the debounce window has no effect here.
    if (DB_CYCLES >= 0) begin : g_no_debounce
        assign stable = sync2;
    end
`endif

    assign press = stable_d & ~stable;

    function automatic logic [4:0] step_val(input logic [3:0] c, input logic down);
        if (down) begin
            return {c == 4'd0, c - 4'd1};
        end
        return {c == 4'd15, c + 4'd1};
    endfunction

    assign tick    = (presc == PRESC_LAST);
    assign stepped = step_val(count, mode[0]);

    // Mode switches take priority over presses; CTRL takes priority over STEP.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            count   <= '0;
            wrap    <= 1'b0;
            running <= 1'b0;
            presc   <= '0;
        end else begin
            wrap <= 1'b0;
            if (!enable) begin
                state   <= IDLE;
                count   <= '0;
                running <= 1'b0;
                presc   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        presc <= '0;
                        if (mode[1]) begin
                            state   <= RUN_AUTO;
                            running <= 1'b1;
                        end else begin
                            state <= RUN_MAN;
                        end
                    end
                    RUN_MAN: begin
                        if (mode[1]) begin
                            state   <= RUN_AUTO;
                            running <= 1'b1;
                            presc   <= '0;
                        end else if (press[1]) begin
                            count <= '0;
                        end else if (press[0]) begin
                            count <= stepped[3:0];
                            wrap  <= stepped[4];
                        end
                    end
                    RUN_AUTO: begin
                        if (!mode[1]) begin
                            state   <= RUN_MAN;
                            running <= 1'b0;
                            presc   <= '0;
                        end else if (press[1]) begin
                            state   <= PAUSE;
                            running <= 1'b0;
                            presc   <= '0;
                        end else if (tick) begin
                            presc <= '0;
                            count <= stepped[3:0];
                            wrap  <= stepped[4];
                        end else begin
                            presc <= presc + 1'b1;
                        end
                    end
                    PAUSE: begin
                        if (!mode[1]) begin
                            state <= RUN_MAN;
                        end else if (press[1]) begin
                            state   <= RUN_AUTO;
                            running <= 1'b1;
                            presc   <= '0;
                        end else if (press[0]) begin
                            count <= stepped[3:0];
                            wrap  <= stepped[4];
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        running <= 1'b0;
                        presc   <= '0;
                    end
                endcase
            end
        end
    end

    // Active-low gfedcba, one cycle behind count.
    always_ff @(posedge clock) begin
        if (reset) begin
            seg <= 7'b1000000;
        end else begin
            case (count)
                4'h0: seg <= 7'b1000000;
                4'h1: seg <= 7'b1111001;
                4'h2: seg <= 7'b0100100;
                4'h3: seg <= 7'b0110000;
                4'h4: seg <= 7'b0011001;
                4'h5: seg <= 7'b0010010;
                4'h6: seg <= 7'b0000010;
                4'h7: seg <= 7'b1111000;
                4'h8: seg <= 7'b0000000;
                4'h9: seg <= 7'b0010000;
                4'hA: seg <= 7'b0001000;
                4'hB: seg <= 7'b0000011;
                4'hC: seg <= 7'b1000110;
                4'hD: seg <= 7'b0100001;
                4'hE: seg <= 7'b0000110;
                4'hF: seg <= 7'b0001110;
            endcase
        end
    end

endmodule

// File: tb/tb_l2_count_ctrl.sv
// Bench for l2_count_ctrl: directed scenarios plus randomized keys/modes/enable/reset
// against a behavioural model of the key path and the counter rules.
module tb_l2_count_ctrl;

    localparam int TICK = 8;
    localparam int DB   = 4;
`ifdef DEBOUNCE_EN
    localparam bit DEB = 1'b1;
`else
    localparam bit DEB = 1'b0;
`endif
    localparam int LAT = DEB ? DB + 3 : 3;

    logic       clock  = 1'b0;
    logic       reset  = 1'b1;
    logic       enable = 1'b0;
    logic [1:0] key_n  = 2'b11;
    logic [1:0] mode   = 2'b00;
    logic [3:0] count;
    logic [6:0] seg;
    logic       wrap;
    logic       running;

    int total = 0;
    int bad   = 0;

    l2_count_ctrl #(.TICK_DIV(TICK), .DB_CYCLES(DB)) dut (
        .clock   (clock),
        .reset   (reset),
        .enable  (enable),
        .key_n   (key_n),
        .mode    (mode),
        .count   (count),
        .seg     (seg),
        .wrap    (wrap),
        .running (running)
    );

    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    logic [6:0] segtab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    typedef enum {M_IDLE, M_MAN, M_AUTO, M_PAUSE} mstate_t;
    mstate_t    ms       = M_IDLE;
    int         m_count  = 0;
    int         elapsed  = 0;
    bit         m_wrap   = 1'b0;
    bit         m_run    = 1'b0;
    logic [6:0] m_seg    = 7'b1000000;
    logic [1:0] k1       = 2'b11;   // key_n seen one edge ago
    logic [1:0] k2       = 2'b11;   // key_n seen two edges ago
    logic [1:0] lvl      = 2'b11;
    logic [1:0] lvl_prev = 2'b11;
    logic [1:0] last_x   = 2'b11;
    int         run_len [2] = '{0, 0};

    always @(posedge clock) begin : model_blk
        logic [1:0] x;
        logic [1:0] pr;
        bit         do_step;
        if (reset) begin
            ms = M_IDLE; m_count = 0; elapsed = 0; m_wrap = 0; m_run = 0;
            m_seg = 7'b1000000;
            k1 = 2'b11; k2 = 2'b11; lvl = 2'b11; lvl_prev = 2'b11; last_x = 2'b11;
            run_len[0] = 0; run_len[1] = 0;
        end else begin
            pr = lvl_prev & ~lvl;
            x  = DEB ? k2 : k1;
            lvl_prev = lvl;
            for (int i = 0; i < 2; i++) begin
                if (x[i] == last_x[i]) run_len[i]++;
                else begin run_len[i] = 1; last_x[i] = x[i]; end
                if (!DEB || run_len[i] >= DB) lvl[i] = x[i];
            end
            k2 = k1; k1 = key_n;
            m_seg   = segtab[m_count];
            m_wrap  = 0;
            do_step = 0;
            if (!enable) begin
                ms = M_IDLE; m_count = 0; elapsed = 0;
            end else begin
                case (ms)
                    M_IDLE: begin ms = mode[1] ? M_AUTO : M_MAN; elapsed = 0; end
                    M_MAN: begin
                        if (mode[1]) begin ms = M_AUTO; elapsed = 0; end
                        else if (pr[1]) m_count = 0;
                        else if (pr[0]) do_step = 1;
                    end
                    M_AUTO: begin
                        if (!mode[1]) ms = M_MAN;
                        else if (pr[1]) ms = M_PAUSE;
                        else begin
                            elapsed++;
                            if (elapsed == TICK) begin do_step = 1; elapsed = 0; end
                        end
                    end
                    M_PAUSE: begin
                        if (!mode[1]) ms = M_MAN;
                        else if (pr[1]) begin ms = M_AUTO; elapsed = 0; end
                        else if (pr[0]) do_step = 1;
                    end
                endcase
            end
            if (do_step) begin
                m_wrap  = mode[0] ? (m_count == 0) : (m_count == 15);
                m_count = (m_count + (mode[0] ? 15 : 1)) % 16;
            end
            m_run = (ms == M_AUTO);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic press(input logic [1:0] keys);
        key_n = ~keys;
        cyc(8);
        key_n = 2'b11;
        cyc(8);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        reset = 1'b1; enable = 1'b1; mode = 2'b00; key_n = 2'b11;
        cyc(2);
        total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
        total++; if (seg !== 7'b1000000) begin bad++; $display("FAIL reset_seg: got %b want 1000000", seg); end
        total++; if (wrap !== 1'b0) begin bad++; $display("FAIL reset_wrap: got %b want 0", wrap); end
        total++; if (running !== 1'b0) begin bad++; $display("FAIL reset_running: got %b want 0", running); end
        reset = 1'b0;
        cyc(3);
        total++; if (running !== 1'b0) begin bad++; $display("FAIL reset_release_running: got %b want 0", running); end
    endtask

    task automatic test_manual_wrap;
        int wraps = 0;
        mode = 2'b00;
        for (int p = 1; p <= 16; p++) begin
            key_n = 2'b10;
            for (int e = 1; e <= 8; e++) begin
                @(negedge clock);
                if (wrap === 1'b1) wraps++;
                if (e == LAT - 1) begin
                    total++;
                    if (count !== 4'((p - 1) % 16)) begin bad++; $display("FAIL manual_early p=%0d: got %0d want %0d", p, count, (p - 1) % 16); end
                end
                if (e == LAT) begin
                    total++;
                    if (count !== 4'(p % 16)) begin bad++; $display("FAIL manual_step p=%0d: got %0d want %0d", p, count, p % 16); end
                    total++;
                    if (wrap !== (p == 16)) begin bad++; $display("FAIL manual_wrap p=%0d: got %b want %b", p, wrap, p == 16); end
                end
            end
            key_n = 2'b11;
            for (int e = 0; e < 8; e++) begin
                @(negedge clock);
                if (wrap === 1'b1) wraps++;
            end
        end
        total++; if (wraps != 1) begin bad++; $display("FAIL manual_wrap_total: got %0d want 1", wraps); end
        total++; if (count !== 4'd0) begin bad++; $display("FAIL manual_final: got %0d want 0", count); end
    endtask

    task automatic test_bounce;
        int want = m_count;
        repeat (5) begin
            key_n = 2'b10; cyc(3);
            key_n = 2'b11; cyc(3);
        end
        cyc(8);
        want = (want + (DEB ? 0 : 5)) % 16;
        total++; if (count !== 4'(want)) begin bad++; $display("FAIL bounce_reject: got %0d want %0d", count, want); end
        key_n = 2'b10; cyc(20);
        key_n = 2'b11; cyc(10);
        want = (want + 1) % 16;
        total++; if (count !== 4'(want)) begin bad++; $display("FAIL bounce_long_hold: got %0d want %0d", count, want); end
    endtask

    task automatic test_auto_pause;
        mode = 2'b00;
        press(2'b10);
        press(2'b01);
        press(2'b01);
        total++; if (count !== 4'd2) begin bad++; $display("FAIL auto_setup: got %0d want 2", count); end
        mode = 2'b11;
        @(negedge clock);
        total++; if (running !== 1'b1) begin bad++; $display("FAIL auto_running: got %b want 1", running); end
        for (int e = 1; e <= 24; e++) begin
            @(negedge clock);
            if (e == 7) begin
                total++; if (count !== 4'd2) begin bad++; $display("FAIL auto_e7: got %0d want 2", count); end
            end
            if (e == 8) begin
                total++; if (count !== 4'd1) begin bad++; $display("FAIL auto_e8: got %0d want 1", count); end
            end
            if (e == 16) begin
                total++; if (count !== 4'd0 || wrap !== 1'b0) begin bad++; $display("FAIL auto_e16: got %0d/%b want 0/0", count, wrap); end
            end
            if (e == 24) begin
                total++; if (count !== 4'd15) begin bad++; $display("FAIL auto_e24: got %0d want 15", count); end
                total++; if (wrap !== 1'b1) begin bad++; $display("FAIL auto_e24_wrap: got %b want 1", wrap); end
            end
        end
        press(2'b10);
        total++; if (running !== 1'b0) begin bad++; $display("FAIL pause_running: got %b want 0", running); end
        total++; if (count !== 4'd15) begin bad++; $display("FAIL pause_entry: got %0d want 15", count); end
        cyc(20);
        total++; if (count !== 4'd15) begin bad++; $display("FAIL pause_frozen: got %0d want 15", count); end
        press(2'b01);
        total++; if (count !== 4'd14) begin bad++; $display("FAIL pause_step: got %0d want 14", count); end
        press(2'b10);
        total++; if (running !== 1'b1) begin bad++; $display("FAIL resume_running: got %b want 1", running); end
        total++; if (count !== 4'(m_count)) begin bad++; $display("FAIL resume_count: got %0d want %0d", count, m_count); end
    endtask

    task automatic test_simultaneous;
        int wraps = 0;
        mode = 2'b00;
        cyc(2);
        press(2'b10);
        repeat (9) press(2'b01);
        total++; if (count !== 4'd9) begin bad++; $display("FAIL simul_setup: got %0d want 9", count); end
        key_n = 2'b00;
        for (int e = 0; e < 16; e++) begin
            if (e == 8) key_n = 2'b11;
            @(negedge clock);
            if (wrap === 1'b1) wraps++;
        end
        total++; if (count !== 4'd0) begin bad++; $display("FAIL simul_clear: got %0d want 0", count); end
        total++; if (wraps != 0) begin bad++; $display("FAIL simul_wrap: got %0d pulses want 0", wraps); end
        mode = 2'b10;
        press(2'b10);
        total++; if (running !== 1'b0) begin bad++; $display("FAIL simul_pause: got %b want 0", running); end
        key_n = 2'b00;
        cyc(8);
        total++; if (running !== 1'b1) begin bad++; $display("FAIL simul_resume: got %b want 1", running); end
        total++; if (count !== 4'd0) begin bad++; $display("FAIL simul_drop_step: got %0d want 0", count); end
        key_n = 2'b11;
        cyc(8);
    endtask

    task automatic test_mode_enable;
        mode = 2'b00;
        cyc(2);
        press(2'b10);
        repeat (5) press(2'b01);
        total++; if (count !== 4'd5) begin bad++; $display("FAIL mode_setup: got %0d want 5", count); end
        mode = 2'b10;
        @(negedge clock);
        for (int e = 1; e <= 9; e++) begin
            @(negedge clock);
            if (e == 7) begin
                total++; if (count !== 4'd5) begin bad++; $display("FAIL mode_e7: got %0d want 5", count); end
            end
            if (e == 8) begin
                total++; if (count !== 4'd6) begin bad++; $display("FAIL mode_e8: got %0d want 6", count); end
                total++; if (seg !== 7'b0010010) begin bad++; $display("FAIL seg_lag: got %b want 0010010", seg); end
            end
            if (e == 9) begin
                total++; if (seg !== 7'b0000010) begin bad++; $display("FAIL seg_follow: got %b want 0000010", seg); end
            end
        end
        enable = 1'b0;
        @(negedge clock);
        total++; if (count !== 4'd0 || running !== 1'b0) begin bad++; $display("FAIL disable: got %0d/%b want 0/0", count, running); end
        press(2'b01);
        total++; if (count !== 4'd0) begin bad++; $display("FAIL disabled_press: got %0d want 0", count); end
        enable = 1'b1;
        cyc(2);
        total++; if (running !== 1'b1) begin bad++; $display("FAIL reenable_auto: got %b want 1", running); end
    endtask

    task automatic test_reset_mid;
        mode = 2'b10; enable = 1'b1;
        cyc(5);
        key_n = 2'b10;
        cyc(2);
        reset = 1'b1;
        @(negedge clock);
        total++; if (count !== 4'd0 || wrap !== 1'b0 || running !== 1'b0) begin bad++; $display("FAIL midreset: got %0d/%b/%b want 0/0/0", count, wrap, running); end
        key_n = 2'b11;
        reset = 1'b0;
        @(negedge clock);
        for (int e = 1; e <= 8; e++) begin
            @(negedge clock);
            if (e == 7) begin
                total++; if (count !== 4'd0) begin bad++; $display("FAIL midreset_presc: got %0d want 0", count); end
            end
            if (e == 8) begin
                total++; if (count !== 4'd1) begin bad++; $display("FAIL midreset_tick: got %0d want 1", count); end
            end
        end
    endtask

    task automatic test_random;
        int hold [2];
        hold[0] = 1; hold[1] = 1;
        reset = 1'b0; enable = 1'b1; key_n = 2'b11;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clock);
            total++; if (count !== 4'(m_count)) begin bad++; $display("FAIL rand_count cyc=%0d: got %0d want %0d", i, count, m_count); end
            total++; if (wrap !== m_wrap) begin bad++; $display("FAIL rand_wrap cyc=%0d: got %b want %b", i, wrap, m_wrap); end
            total++; if (running !== m_run) begin bad++; $display("FAIL rand_running cyc=%0d: got %b want %b", i, running, m_run); end
            total++; if (seg !== m_seg) begin bad++; $display("FAIL rand_seg cyc=%0d: got %b want %b", i, seg, m_seg); end
            reset = ($urandom_range(0, 299) == 0);
            if (enable) begin
                if ($urandom_range(0, 199) == 0) enable = 1'b0;
            end else if ($urandom_range(0, 9) == 0) begin
                enable = 1'b1;
            end
            if ($urandom_range(0, 59) == 0) mode = 2'($urandom_range(0, 3));
            for (int k = 0; k < 2; k++) begin
                hold[k]--;
                if (hold[k] == 0) begin
                    key_n[k] = ~key_n[k];
                    hold[k]  = $urandom_range(1, 12);
                end
            end
        end
        reset = 1'b0; enable = 1'b1; key_n = 2'b11;
    endtask

    initial begin
        test_reset;
        test_manual_wrap;
        test_bounce;
        test_auto_pause;
        test_simultaneous;
        test_mode_enable;
        test_reset_mid;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
